// File: rtl/pulse_window_ctrl.sv
// Gated pulse counter: on start, counts rising edges of the debounced input over a
// fixed GATE_CYCLES window and publishes the result with a one-cycle done strobe.
// Define PULSE_WINDOW_SAT_EN to make the working counter saturate instead of wrap.
module pulse_window_ctrl #(
    parameter int CNT_W       = 16,
    parameter int GATE_CYCLES = 1000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clean,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int GATE_W = $clog2(GATE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        COUNT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               prev;
    logic [GATE_W-1:0]  timer;
    logic [CNT_W-1:0]   work_cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               work_ovf;
    logic               ovf_nxt;
    logic               rise;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort wins over the timer expiring, so an aborted window never publishes.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !abort) state_nxt = ARM;
            ARM:     state_nxt = abort ? IDLE : COUNT;
            COUNT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (timer == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rise    = clean & ~prev;
        cnt_nxt = work_cnt;
        ovf_nxt = work_ovf;
        if (rise) begin
            if (&work_cnt) begin
                ovf_nxt = 1'b1;
`ifdef PULSE_WINDOW_SAT_EN
                cnt_nxt = work_cnt;
`else
                cnt_nxt = '0;
`endif
            end else begin
                cnt_nxt = work_cnt + CNT_W'(1);
            end
        end
    end

    // Results are taken from the next-value logic so an edge in the final counted
    // cycle lands in the published count.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
            prev     <= 1'b0;
            timer    <= '0;
            work_cnt <= '0;
            work_ovf <= 1'b0;
        end else begin
            busy <= (state_nxt == COUNT);
            done <= (state_nxt == DONE);
            case (state)
                ARM: begin
                    work_cnt <= '0;
                    work_ovf <= 1'b0;
                    timer    <= GATE_W'(GATE_CYCLES - 1);
                    prev     <= clean;
                end
                COUNT: begin
                    prev     <= clean;
                    work_cnt <= cnt_nxt;
                    work_ovf <= ovf_nxt;
                    if (timer != '0) begin
                        timer <= timer - GATE_W'(1);
                    end
                    if (state_nxt == DONE) begin
                        count    <= cnt_nxt;
                        overflow <= ovf_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_window_ctrl.sv
// Directed bench for pulse_window_ctrl: a 16-bit and a 4-bit counter instance share
// stimulus; window vectors come from a table, abort/reset/ignored-start are hand sequences.
module tb_pulse_window_ctrl;

    localparam int GATE = 100;

    logic        clock;
    logic        reset;
    logic        clean;
    logic        start;
    logic        abort;
    logic        busy16;
    logic        done16;
    logic [15:0] count16;
    logic        ovf16;
    logic        busy4;
    logic        done4;
    logic [3:0]  count4;
    logic        ovf4;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int mode;
        int p;
        int h;
        int restart;
        int exp16;
        int ovf16;
        int exp4;
        int ovf4;
    } vec_t;

    vec_t vecs[7];

    pulse_window_ctrl #(.CNT_W(16), .GATE_CYCLES(GATE)) dut16 (
        .clock(clock), .reset(reset), .clean(clean), .start(start), .abort(abort),
        .busy(busy16), .done(done16), .count(count16), .overflow(ovf16)
    );

    pulse_window_ctrl #(.CNT_W(4), .GATE_CYCLES(GATE)) dut4 (
        .clock(clock), .reset(reset), .clean(clean), .start(start), .abort(abort),
        .busy(busy4), .done(done4), .count(count4), .overflow(ovf4)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic applyStimulus(input logic s, input logic a, input logic c);
        start = s;
        abort = a;
        clean = c;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Clean level sampled at edge k+i, where edge k samples start.
    function automatic logic cleanAt(input vec_t v, input int i);
        case (v.mode)
            0:       return (i >= 2) && (((i - 2) % v.p) < v.h);
            1:       return i == v.p;
            default: return 1'b1;
        endcase
    endfunction

    task automatic runWindow(input vec_t v, input string tag);
        int          busyRise;
        int          busyFall;
        int          doneCnt;
        int          doneEdge;
        logic [15:0] c16;
        logic        o16;
        logic [3:0]  c4;
        logic        o4;
        busyRise = -1;
        busyFall = -1;
        doneCnt  = 0;
        doneEdge = -1;
        c16 = 'x;
        o16 = 1'bx;
        c4  = 'x;
        o4  = 1'bx;
        applyStimulus(1'b1, 1'b0, cleanAt(v, 0));
        for (int i = 1; i <= GATE + 10; i++) begin
            applyStimulus(i == v.restart, 1'b0, cleanAt(v, i));
            if (busy16 && busyRise < 0) busyRise = i;
            if (!busy16 && busyRise >= 0 && busyFall < 0) busyFall = i;
            if (done16) begin
                doneCnt++;
                doneEdge = i;
                c16 = count16;
                o16 = ovf16;
                c4  = count4;
                o4  = ovf4;
            end
        end
        checkOutput({tag, "_busy_rise"}, busyRise, 1);
        checkOutput({tag, "_busy_fall"}, busyFall, GATE + 1);
        checkOutput({tag, "_done_edge"}, doneEdge, GATE + 1);
        checkOutput({tag, "_done_count"}, doneCnt, 1);
        checkOutput({tag, "_count16"}, c16, v.exp16);
        checkOutput({tag, "_ovf16"}, o16, v.ovf16);
        checkOutput({tag, "_count4"}, c4, v.exp4);
        checkOutput({tag, "_ovf4"}, o4, v.ovf4);
    endtask

    initial begin
        int seen;

        vecs[0] = '{0, 10, 5, 0, 10, 0, 10, 0};
        vecs[1] = '{2, 0, 0, 0, 0, 0, 0, 0};
`ifdef PULSE_WINDOW_SAT_EN
        vecs[2] = '{0, 5, 2, 0, 20, 0, 15, 1};
`else
        vecs[2] = '{0, 5, 2, 0, 20, 0, 4, 1};
`endif
        vecs[3] = '{1, GATE + 1, 0, 0, 1, 0, 1, 0};
        vecs[4] = '{1, 1, 0, 0, 0, 0, 0, 0};
        vecs[5] = '{1, GATE + 2, 0, 0, 0, 0, 0, 0};
        vecs[6] = '{0, 10, 5, 50, 10, 0, 10, 0};

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("reset_outputs", {busy16, done16, ovf16, count16}, 0);
        end
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (busy16 || done16) seen++;
        end
        checkOutput("post_reset_quiet", seen, 0);

        for (int n = 0; n < 7; n++) begin
            runWindow(vecs[n], $sformatf("vec%0d", n));
        end

        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 50; i++) applyStimulus(1'b0, 1'b0, cleanAt(vecs[0], i));
        applyStimulus(1'b0, 1'b1, cleanAt(vecs[0], 51));
        checkOutput("abort_busy", busy16, 0);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (done16 || busy16) seen++;
        end
        checkOutput("abort_no_done", seen, 0);
        checkOutput("abort_count16", count16, 10);
        checkOutput("abort_count4", count4, 10);

        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        seen = 0;
        for (int i = 0; i < GATE + 10; i++) begin
            if (busy16 || done16) seen++;
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        checkOutput("abort_arm_quiet", seen, 0);
        checkOutput("abort_arm_count16", count16, 10);

        applyStimulus(1'b1, 1'b1, 1'b0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy16 || done16) seen++;
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        checkOutput("start_abort_idle", seen, 0);

        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 30; i++) applyStimulus(1'b0, 1'b0, cleanAt(vecs[0], i));
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        checkOutput("midreset_outputs", {busy16, done16, ovf16, count16}, 0);
        checkOutput("midreset_count4", count4, 0);
        seen = 0;
        for (int i = 0; i < GATE + 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (busy16 || done16) seen++;
        end
        checkOutput("midreset_no_done", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
